// File: rtl/mul_mf_pkg.sv
// Shared types and width helpers for the multi-flux coefficient multiplier.
package mul_mf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WORK = 1'b1
   } state_t;

   localparam int PROD_W_DEF = 18;

   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int prod_width(input int a_w, input int c_w);
      return a_w + 1 + c_w;
   endfunction

endpackage

// File: rtl/mul_mf_if.sv
// FIFO-side read/write handshakes and the context RAM port bundle.
interface read_interface #(
   parameter int W = 8,
   parameter int N = 2
);
   logic [W-1:0] dout;
   logic [N-1:0] empty;
   logic [N-1:0] read;
   modport actor (input dout, input empty, output read);
   modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
   parameter int W = 8,
   parameter int N = 2
);
   logic [W-1:0] din;
   logic [N-1:0] full;
   logic [N-1:0] write;
   modport actor (output din, output write, input full);
   modport fifo  (input din, input write, output full);
endinterface

interface ram_interface #(
   parameter int W  = 8,
   parameter int AW = 1
);
   logic          we;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic [W-1:0]  wdata;
   logic [W-1:0]  rdata;
   modport ram  (input we, input waddr, input wdata,
                 input raddr, output rdata);
   modport user (output we, output waddr, output wdata,
                 output raddr, input rdata);
endinterface

// File: rtl/mul_coeff_mf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer to grant+1.
import mul_mf_pkg::*;

module rr_arbiter #(
   parameter int N = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            i_req,
   output logic [N-1:0]            o_gnt,
   output logic [tag_width(N)-1:0] o_idx,
   output logic                    o_any
);

   localparam int IW = tag_width(N);

   logic [IW-1:0] r_ptr;

   // Walk down so the request nearest the pointer wins last.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         automatic int j = (int'(r_ptr) + k) % N;
         if (i_req[IW'(j)]) begin
            o_idx = IW'(j);
            o_any = 1'b1;
         end
      end
      o_gnt = o_any ? (N'(1) << o_idx) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (o_any) begin
         r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + IW'(1);
      end
   end

endmodule

// File: rtl/ram_dual_ported.sv
// Dual-ported context RAM: one sync write port, one async read port.
module ram_dual_ported #(
   parameter int W  = 8,
   parameter int AW = 1
) (
   input logic   clk,
   input logic   rst,
   ram_interface.ram io
);

   logic [W-1:0] r_mem [2**AW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
      end else if (io.we) begin
         r_mem[io.waddr] <= io.wdata;
      end
   end

   assign io.rdata = r_mem[io.raddr];

endmodule

// File: rtl/mul_coeff_mf.sv
// Multi-flux coefficient multiplier, one N*N block per coefficient.
// SAT_SHIFT_EN adds rounding right shift and saturation to OUT_W.
import mul_mf_pkg::*;

module mul_coeff_mf #(
   parameter int FLUX       = 2,
   parameter int OPA_W      = 8,
   parameter int OPA_SIGNED = 0,
   parameter int COEF_W     = 9,
   parameter int SIZE_W     = 7,
   parameter int OUT_W      = PROD_W_DEF,
   parameter int SHIFT      = 0
) (
   input logic           clk,
   input logic           rst,
   read_interface.actor  read_port_opA,
   read_interface.actor  read_port_opB,
   read_interface.actor  read_port_ext_size,
   write_interface.actor write_port_prod
);

   localparam int TAG_W = tag_width(FLUX);
   localparam int PW    = prod_width(OPA_W, COEF_W);
   localparam int CTX_W = COEF_W + 3 * SIZE_W;

   state_t              r_state [FLUX];
   logic                r_pv;
   logic [TAG_W-1:0]    r_ptag;
   logic [OUT_W-1:0]    r_pdat;

   logic [FLUX-1:0]     w_req;
   logic [FLUX-1:0]     w_gnt;
   logic [FLUX-1:0]     w_idle;
   logic [TAG_W-1:0]    w_idx;
   logic                w_any;
   logic                w_load;
   logic                w_work;

   logic [COEF_W-1:0]   w_coef;
   logic [SIZE_W-1:0]   w_max;
   logic [SIZE_W-1:0]   w_ch;
   logic [SIZE_W-1:0]   w_cv;
   logic [SIZE_W-1:0]   w_nch;
   logic [SIZE_W-1:0]   w_ncv;
   logic [SIZE_W-1:0]   w_nsz;
   logic                w_hlast;
   logic                w_vlast;

   logic [OPA_W:0]      w_aext;
   logic signed [PW-1:0] w_ax;
   logic signed [PW-1:0] w_cx;
   logic signed [PW-1:0] w_prod;
   logic [OUT_W-1:0]    w_res;
   logic                w_unused;

   localparam int UNUSED_SHIFT = SHIFT;

   ram_interface #(.W(CTX_W), .AW(TAG_W)) ctx ();

   ram_dual_ported #(.W(CTX_W), .AW(TAG_W)) u_ctx (
      .clk (clk),
      .rst (rst),
      .io  (ctx)
   );

   rr_arbiter #(.N(FLUX)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_req),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Requests are masked in reset so every read strobe drops at once.
   always_comb begin
      for (int c = 0; c < FLUX; c++) begin
         w_idle[c] = (r_state[c] == IDLE);
         w_req[c]  = !rst && (w_idle[c]
            ? (!read_port_opB.empty[c] &&
               !read_port_ext_size.empty[c])
            : (!read_port_opA.empty[c] &&
               !write_port_prod.full[c] &&
               !(r_pv && r_ptag == TAG_W'(c))));
      end
   end

   assign w_load = w_any && w_idle[w_idx];
   assign w_work = w_any && !w_idle[w_idx];

   assign read_port_opB.read      = w_gnt & w_idle;
   assign read_port_ext_size.read = w_gnt & w_idle;
   assign read_port_opA.read      = w_gnt & ~w_idle;

   assign {w_coef, w_max, w_ch, w_cv} = ctx.rdata;
   assign w_nsz   = read_port_ext_size.dout[SIZE_W-1:0];
   assign w_hlast = (w_ch == w_max - SIZE_W'(1));
   assign w_vlast = (w_cv == w_max - SIZE_W'(1));

   always_comb begin
      w_nch = '0;
      w_ncv = '0;
      if (!w_hlast) begin
         w_nch = w_ch + SIZE_W'(1);
         w_ncv = w_cv;
      end else if (!w_vlast) begin
         w_ncv = w_cv + SIZE_W'(1);
      end
   end

   assign ctx.raddr = w_idx;
   assign ctx.waddr = w_idx;
   assign ctx.we    = w_any;
   assign ctx.wdata = w_load
      ? {read_port_opB.dout[COEF_W-1:0], w_nsz,
         {(2 * SIZE_W){1'b0}}}
      : {w_coef, w_max, w_nch, w_ncv};

   assign w_aext = (OPA_SIGNED != 0)
      ? {read_port_opA.dout[OPA_W-1], read_port_opA.dout[OPA_W-1:0]}
      : {1'b0, read_port_opA.dout[OPA_W-1:0]};
   assign w_ax   = PW'($signed(w_aext));
   assign w_cx   = PW'($signed(w_coef));
   assign w_prod = w_ax * w_cx;

`ifdef SAT_SHIFT_EN
   localparam int XW = ((OUT_W > PW) ? OUT_W : PW) + 2;
   localparam logic signed [XW-1:0] C_RND =
      XW'((1 << SHIFT) >> 1);
   localparam logic signed [XW-1:0] C_MAX =
      XW'((longint'(1) <<< (OUT_W - 1)) - 1);
   localparam logic signed [XW-1:0] C_MIN = -C_MAX - XW'(1);

   logic signed [XW-1:0] w_sh;

   assign w_sh  = (XW'(w_prod) + C_RND) >>> SHIFT;
   assign w_res = (w_sh > C_MAX) ? OUT_W'(C_MAX)
                : (w_sh < C_MIN) ? OUT_W'(C_MIN)
                : OUT_W'(w_sh);
`else
   assign w_res = OUT_W'(w_prod);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < FLUX; c++) r_state[c] <= IDLE;
         r_pv   <= 1'b0;
         r_ptag <= '0;
         r_pdat <= '0;
      end else begin
         r_pv <= w_work;
         if (w_work) begin
            r_ptag <= w_idx;
            r_pdat <= w_res;
         end
         if (w_load && w_nsz != '0) r_state[w_idx] <= WORK;
         if (w_work && w_hlast && w_vlast) r_state[w_idx] <= IDLE;
      end
   end

   assign write_port_prod.write = r_pv ? (FLUX'(1) << r_ptag) : '0;
   assign write_port_prod.din   = {r_ptag, r_pdat};

   assign w_unused = ^{read_port_opA.dout[OPA_W+TAG_W-1:OPA_W],
                       read_port_opB.dout[COEF_W+TAG_W-1:COEF_W],
                       read_port_ext_size.dout[SIZE_W+TAG_W-1:SIZE_W]};

endmodule
